// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request/response bus between the two ALU requesters and the
// arbiter. Each 2-bit handshake vector carries one bit per requester. Operand
// buses are packed with requester i's operand in slice i. The result bus
// (resp_sum/resp_eq) is shared and is only meaningful where resp_valid is set.
//
//   master : requester side (drives requests, consumes results)
//   slave  : arbiter side
interface alu_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  logic [1:0]              req_valid;
  logic [1:0]              req_ready;
  logic [2*DATA_WIDTH-1:0] req_op1;
  logic [2*DATA_WIDTH-1:0] req_op2;
  logic [1:0]              req_ctrl;
  logic [1:0]              resp_valid;
  logic [1:0]              resp_ready;
  logic [DATA_WIDTH-1:0]   resp_sum;
  logic                    resp_eq;

  modport master (
    output req_valid, req_op1, req_op2, req_ctrl, resp_ready,
    input  req_ready, resp_valid, resp_sum, resp_eq
  );

  modport slave (
    input  req_valid, req_op1, req_op2, req_ctrl, resp_ready,
    output req_ready, resp_valid, resp_sum, resp_eq
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one single-cycle ALU (add / equality compare) between
// the execute stage (requester 0) and the auxiliary PC/branch-target path
// (requester 1). One transaction at a time: accept, drive the ALU from
// registered operands for one cycle, then hold a registered result until the
// owning requester consumes it.
//
// Ports:
//   clk      core clock, all state updates on the rising edge
//   rst      synchronous, active-high reset
//   bus      alu_arbiter_if.slave - request/response handshakes per requester
//   alu_op1  ALU operand 1 (registered)
//   alu_op2  ALU operand 2 (registered)
//   alu_ctrl ALU op select, 0 = add, 1 = compare (registered)
//   alu_sum  ALU sum result
//   alu_eq   ALU equality result
//
// Build option:
//   ALU_ARB_FIXED_PRIO_EN - when defined, requester 0 always wins contention;
//   otherwise contention is resolved round-robin against last_grant.
//
// state | meaning
// IDLE  | waiting for a request; req_ready offers the grant combinationally
// EXEC  | registered operands on the ALU; result captured at the cycle end
// RESP  | result held on resp_*; waits for resp_ready of the owner
module alu_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  alu_arbiter_if.slave          bus,
  output logic [DATA_WIDTH-1:0] alu_op1,
  output logic [DATA_WIDTH-1:0] alu_op2,
  output logic                  alu_ctrl,
  input  logic [DATA_WIDTH-1:0] alu_sum,
  input  logic                  alu_eq
);

`ifdef ALU_ARB_FIXED_PRIO_EN
  localparam bit FIXED_PRIO = 1'b1;
`else
  localparam bit FIXED_PRIO = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] op1_q, op2_q, resp_sum_q;
  logic                  ctrl_q, owner_q, last_grant_q, resp_eq_q;
  logic [1:0]            resp_valid_q;
  logic [1:0]            req_ready_c;
  logic                  grant_id;
  logic                  accept, capture, rsp_done;

  // Grant selection: a lone requester always wins; under contention the
  // requester that did not win last time goes next (or requester 0 when
  // fixed priority is built in).
  always_comb begin
    grant_id = 1'b0;
    if (bus.req_valid == 2'b10) begin
      grant_id = 1'b1;
    end else if (bus.req_valid == 2'b11) begin
      grant_id = FIXED_PRIO ? 1'b0 : ~last_grant_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    req_ready_c = 2'b00;
    accept      = 1'b0;
    capture     = 1'b0;
    rsp_done    = 1'b0;
    case (state)
      IDLE: begin
        if (|bus.req_valid) begin
          req_ready_c = grant_id ? 2'b10 : 2'b01;
          accept      = 1'b1;
          state_nxt   = EXEC;
        end
      end
      EXEC: begin
        capture   = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        // Only the owner's resp_ready matters; the other bit is ignored.
        if (bus.resp_ready[owner_q]) begin
          rsp_done  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // No handshake may complete while reset is held.
    if (rst) begin
      req_ready_c = 2'b00;
      accept      = 1'b0;
      capture     = 1'b0;
      rsp_done    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op1_q        <= '0;
      op2_q        <= '0;
      ctrl_q       <= 1'b0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      resp_valid_q <= 2'b00;
      resp_sum_q   <= '0;
      resp_eq_q    <= 1'b0;
    end else begin
      if (accept) begin
        op1_q        <= grant_id ? bus.req_op1[2*DATA_WIDTH-1:DATA_WIDTH]
                                 : bus.req_op1[DATA_WIDTH-1:0];
        op2_q        <= grant_id ? bus.req_op2[2*DATA_WIDTH-1:DATA_WIDTH]
                                 : bus.req_op2[DATA_WIDTH-1:0];
        ctrl_q       <= bus.req_ctrl[grant_id];
        owner_q      <= grant_id;
        last_grant_q <= grant_id;
      end
      if (capture) begin
        resp_valid_q[owner_q] <= 1'b1;
        // On compare the ALU leaves SUM undriven, so it is never forwarded.
        if (ctrl_q) begin
          resp_sum_q <= '0;
          resp_eq_q  <= alu_eq;
        end else begin
          resp_sum_q <= alu_sum;
          resp_eq_q  <= 1'b0;
        end
      end
      if (rsp_done) begin
        resp_valid_q <= 2'b00;
      end
    end
  end

  assign alu_op1        = op1_q;
  assign alu_op2        = op2_q;
  assign alu_ctrl       = ctrl_q;
  assign bus.req_ready  = req_ready_c;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_sum   = resp_sum_q;
  assign bus.resp_eq    = resp_eq_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed bench for alu_arbiter. A behavioural ALU drives
// alu_sum/alu_eq from the arbiter's ALU outputs; on compare it puts a junk
// value on SUM and on add a junk EQ so that forwarding the wrong field shows.
// Builds with or without ALU_ARB_FIXED_PRIO_EN.
module tb_alu_arbiter;
  localparam int W = 32;
`ifdef ALU_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic [W-1:0] alu_op1, alu_op2, alu_sum;
  logic         alu_ctrl, alu_eq;
  int           errors;
  int           checks;

  alu_arbiter_if #(.DATA_WIDTH(W)) bus ();

  alu_arbiter #(.DATA_WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .alu_op1  (alu_op1),
    .alu_op2  (alu_op2),
    .alu_ctrl (alu_ctrl),
    .alu_sum  (alu_sum),
    .alu_eq   (alu_eq)
  );

  assign alu_sum = alu_ctrl ? 32'hDEAD_BEEF : alu_op1 + alu_op2;
  assign alu_eq  = alu_ctrl ? (alu_op1 == alu_op2) : 1'b1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int idx, input logic ctrl, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.req_ctrl[idx]        = ctrl;
    bus.req_op1[idx*W +: W]  = a;
    bus.req_op2[idx*W +: W]  = b;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst            = 1'b1;
    bus.req_valid  = 2'b11;
    bus.req_op1    = '0;
    bus.req_op2    = '0;
    bus.req_ctrl   = 2'b00;
    bus.resp_ready = 2'b11;

    // Reset state, with both requesters pushing during reset.
    tick();
    tick();
    check("rst_req_ready", 64'(bus.req_ready), 64'h0);
    check("rst_resp_valid", 64'(bus.resp_valid), 64'h0);
    check("rst_resp_sum", 64'(bus.resp_sum), 64'h0);
    check("rst_resp_eq", 64'(bus.resp_eq), 64'h0);
    check("rst_alu_op1", 64'(alu_op1), 64'h0);
    check("rst_alu_op2", 64'(alu_op2), 64'h0);
    check("rst_alu_ctrl", 64'(alu_ctrl), 64'h0);
    bus.req_valid = 2'b00;
    rst = 1'b0;
    tick();

    // Single add from requester 0: 5 + 7.
    set_req(0, 1'b0, 32'd5, 32'd7);
    bus.req_valid = 2'b01;
    #1;
    check("t1_ready_idle", 64'(bus.req_ready), 64'h1);
    tick();
    bus.req_valid = 2'b00;
    #1;
    check("t1_ready_exec", 64'(bus.req_ready), 64'h0);
    check("t1_alu_op1", 64'(alu_op1), 64'd5);
    check("t1_alu_op2", 64'(alu_op2), 64'd7);
    check("t1_valid_exec", 64'(bus.resp_valid), 64'h0);
    tick();
    check("t1_resp_valid", 64'(bus.resp_valid), 64'h1);
    check("t1_resp_sum", 64'(bus.resp_sum), 64'd12);
    check("t1_resp_eq", 64'(bus.resp_eq), 64'h0);
    check("t1_ready_resp", 64'(bus.req_ready), 64'h0);
    tick();
    check("t1_valid_done", 64'(bus.resp_valid), 64'h0);

    // Contention right after reset: req0 compare 9==9, req1 add wrap.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_req(0, 1'b1, 32'd9, 32'd9);
    set_req(1, 1'b0, 32'hFFFF_FFFF, 32'd1);
    bus.req_valid = 2'b11;
    #1;
    check("t2_first_grant", 64'(bus.req_ready), 64'h1);
    tick();
    bus.req_valid = 2'b10;
    #1;
    check("t2_ready_exec", 64'(bus.req_ready), 64'h0);
    check("t2_alu_ctrl", 64'(alu_ctrl), 64'h1);
    tick();
    check("t2_r0_valid", 64'(bus.resp_valid), 64'h1);
    check("t2_r0_eq", 64'(bus.resp_eq), 64'h1);
    check("t2_r0_sum", 64'(bus.resp_sum), 64'h0);
    tick();
    check("t2_second_grant", 64'(bus.req_ready), 64'h2);
    tick();
    bus.req_valid = 2'b00;
    check("t2_alu_op1", 64'(alu_op1), 64'hFFFF_FFFF);
    tick();
    check("t2_r1_valid", 64'(bus.resp_valid), 64'h2);
    check("t2_r1_sum", 64'(bus.resp_sum), 64'h0);
    check("t2_r1_eq", 64'(bus.resp_eq), 64'h0);
    tick();

    // Both continuously valid for four transactions.
    set_req(0, 1'b0, 32'd1, 32'd2);
    set_req(1, 1'b0, 32'd10, 32'd20);
    bus.req_valid = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
      automatic logic id = FIXED ? 1'b0 : k[0];
      check("t3_grant", 64'(bus.req_ready), id ? 64'h2 : 64'h1);
      tick();
      check("t3_alu_op1", 64'(alu_op1), id ? 64'd10 : 64'd1);
      tick();
      check("t3_resp_valid", 64'(bus.resp_valid), id ? 64'h2 : 64'h1);
      check("t3_resp_sum", 64'(bus.resp_sum), id ? 64'd30 : 64'd3);
      tick();
    end
    bus.req_valid = 2'b00;
    tick();

    // req1 compare 3 vs 4 with its resp_ready held low; req0 waits.
    set_req(1, 1'b1, 32'd3, 32'd4);
    bus.req_valid  = 2'b10;
    bus.resp_ready = 2'b01;
    #1;
    check("t4_grant1", 64'(bus.req_ready), 64'h2);
    tick();
    set_req(0, 1'b0, 32'd100, 32'd1);
    bus.req_valid = 2'b01;
    #1;
    check("t4_ready_exec", 64'(bus.req_ready), 64'h0);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("t4_hold_valid", 64'(bus.resp_valid), 64'h2);
      check("t4_hold_eq", 64'(bus.resp_eq), 64'h0);
      check("t4_hold_sum", 64'(bus.resp_sum), 64'h0);
      check("t4_hold_ready", 64'(bus.req_ready), 64'h0);
      tick();
    end
    bus.resp_ready = 2'b11;
    #1;
    check("t4_rise_ready", 64'(bus.req_ready), 64'h0);
    tick();
    check("t4_released", 64'(bus.resp_valid), 64'h0);
    check("t4_req0_grant", 64'(bus.req_ready), 64'h1);
    tick();
    bus.req_valid = 2'b00;
    tick();
    check("t4_r0_valid", 64'(bus.resp_valid), 64'h1);
    check("t4_r0_sum", 64'(bus.resp_sum), 64'd101);
    check("t4_r0_eq", 64'(bus.resp_eq), 64'h0);
    tick();

    // Reset during EXEC of a req0 add.
    set_req(0, 1'b0, 32'd5, 32'd7);
    bus.req_valid = 2'b01;
    #1;
    check("t5_grant", 64'(bus.req_ready), 64'h1);
    tick();
    bus.req_valid = 2'b00;
    rst = 1'b1;
    check("t5_exec_op1", 64'(alu_op1), 64'd5);
    tick();
    check("t5_rst_valid", 64'(bus.resp_valid), 64'h0);
    check("t5_rst_sum", 64'(bus.resp_sum), 64'h0);
    check("t5_rst_op1", 64'(alu_op1), 64'h0);
    check("t5_rst_op2", 64'(alu_op2), 64'h0);
    rst = 1'b0;
    tick();
    check("t5_no_resp_a", 64'(bus.resp_valid), 64'h0);
    tick();
    check("t5_no_resp_b", 64'(bus.resp_valid), 64'h0);
    set_req(0, 1'b0, 32'd2, 32'd2);
    set_req(1, 1'b0, 32'd3, 32'd3);
    bus.req_valid = 2'b11;
    #1;
    check("t5_grant_after_rst", 64'(bus.req_ready), 64'h1);
    tick();
    bus.req_valid = 2'b10;
    tick();
    check("t5_r0_valid", 64'(bus.resp_valid), 64'h1);
    check("t5_r0_sum", 64'(bus.resp_sum), 64'd4);
    tick();
    check("t5_grant1", 64'(bus.req_ready), 64'h2);
    tick();
    bus.req_valid = 2'b00;
    tick();
    check("t5_r1_valid", 64'(bus.resp_valid), 64'h2);
    check("t5_r1_sum", 64'(bus.resp_sum), 64'd6);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
